// File: rtl/mux_scan_ctrl.sv
// Drives a 16:1 mux one select code at a time and collects each sampled bit into a result word.
// Optional macro MUX_SCAN_PARITY_EN adds a registered out_parity output (XOR of out_data).
module mux_scan_ctrl #(
    parameter int SCAN_LEN  = 16,
    parameter int SEL_START = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [15:0] mux_data,
    output logic [3:0]  mux_sel,
    output logic        mux_en,
    input  logic        mux_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic        out_parity
`endif
);

    localparam logic [3:0] SEL_FIRST = 4'(SEL_START);
    localparam logic [3:0] SEL_LAST  = 4'(SEL_START + SCAN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] sampled;

    // Result word as it will look once the current mux_out sample is folded in.
    always_comb begin
        sampled          = out_data;
        sampled[mux_sel] = mux_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mux_data   <= '0;
            mux_sel    <= '0;
            mux_en     <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state      <= SCAN;
                        mux_data   <= in_data;
                        mux_sel    <= SEL_FIRST;
                        out_data   <= '0;
                        in_ready   <= 1'b0;
                        mux_en     <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        out_parity <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    out_data <= sampled;
                    // The select code parks on the last step so it never wraps.
                    if (mux_sel == SEL_LAST) begin
                        state      <= DONE;
                        mux_en     <= 1'b0;
                        out_valid  <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        out_parity <= ^sampled;
`endif
                    end else begin
                        mux_sel <= mux_sel + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: a default-sized instance and a narrow (SEL_START=4, SCAN_LEN=3) one.
// Expected results come from a mask-based reference model; the external mux is modelled as mux_en & mux_data[mux_sel].
module tb_mux_scan_ctrl;

    localparam int LEN0   = 16;
    localparam int START0 = 0;
    localparam int LEN1   = 3;
    localparam int START1 = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, mux_en, mux_out, out_valid, out_ready;
    logic [15:0] in_data, mux_data, out_data;
    logic [3:0]  mux_sel;
    logic        in_valid2, in_ready2, mux_en2, mux_out2, out_valid2, out_ready2;
    logic [15:0] in_data2, mux_data2, out_data2;
    logic [3:0]  mux_sel2;
`ifdef MUX_SCAN_PARITY_EN
    logic        out_parity, out_parity2;
`endif

    int          total = 0;
    int          bad = 0;
    logic [15:0] lastResult;
    int          lastLatency, lastScan, lastAccept;

    always #5 clk = ~clk;

    assign mux_out  = mux_en & mux_data[mux_sel];
    assign mux_out2 = mux_en2 & mux_data2[mux_sel2];

    mux_scan_ctrl #(.SCAN_LEN(LEN0), .SEL_START(START0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mux_data(mux_data), .mux_sel(mux_sel), .mux_en(mux_en), .mux_out(mux_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MUX_SCAN_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    mux_scan_ctrl #(.SCAN_LEN(LEN1), .SEL_START(START1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .mux_data(mux_data2), .mux_sel(mux_sel2), .mux_en(mux_en2), .mux_out(mux_out2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
`ifdef MUX_SCAN_PARITY_EN
        , .out_parity(out_parity2)
`endif
    );

    function automatic logic [15:0] refResult(input logic [15:0] word, input int start, input int len);
        logic [31:0] m;
        m = ((32'd1 << len) - 32'd1) << start;
        return word & m[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers a word to the default instance and follows it until out_valid, checking each scan step.
    task automatic applyStimulus(input logic [15:0] word, input string tag);
        int edges;
        int expSel;
        edges = 0;
        lastScan = 0;
        lastAccept = 0;
        expSel = START0;
        in_valid = 1'b1;
        in_data = word;
        while ((edges == 0 || !out_valid) && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (mux_en) begin
                if (lastAccept == 0) begin
                    lastAccept = edges;
                    in_valid = 1'b0;
                end
                checkOutput({tag, "_sel"}, 32'(mux_sel), 32'(expSel));
                checkOutput({tag, "_scanhold"}, {15'd0, in_ready, mux_data}, {15'd0, 1'b0, word});
                lastScan++;
                expSel++;
            end
        end
        in_valid = 1'b0;
        checkOutput({tag, "_done"}, 32'(out_valid), 32'd1);
        lastLatency = edges;
        lastResult = out_data;
    endtask

    initial begin
        logic [15:0] word;
        logic [15:0] held;
        int          steps;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        in_valid2 = 1'b0;
        in_data2 = '0;
        out_ready2 = 1'b1;
        #12;
        checkOutput("reset_flags", {29'd0, in_ready, out_valid, mux_en}, 32'h4);
        checkOutput("reset_data", {mux_data, out_data}, 32'h0);
        checkOutput("reset_sel", 32'(mux_sel), 32'h0);
        checkOutput("reset_flags2", {29'd0, in_ready2, out_valid2, mux_en2}, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] default scan of A5C3");
        applyStimulus(16'hA5C3, "dflt");
        checkOutput("dflt_result", 32'(lastResult), 32'(refResult(16'hA5C3, START0, LEN0)));
        checkOutput("dflt_latency", 32'(lastLatency), 32'(LEN0 + 1));
        checkOutput("dflt_scan_cycles", 32'(lastScan), 32'(LEN0));
        checkOutput("dflt_accept", 32'(lastAccept), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("dflt_idle", {30'd0, in_ready, out_valid}, 32'h2);

        $display("[TB] random words");
        for (int i = 0; i < 6; i++) begin
            word = 16'($urandom);
            applyStimulus(word, "rand");
            checkOutput("rand_result", 32'(lastResult), 32'(refResult(word, START0, LEN0)));
            checkOutput("rand_latency", 32'(lastLatency), 32'(LEN0 + 1));
            @(posedge clk);
            #1;
        end

        $display("[TB] back-to-back words");
        applyStimulus(16'h1234, "b2b_a");
        checkOutput("b2b_a_result", 32'(lastResult), 32'h1234);
        applyStimulus(16'h8001, "b2b_b");
        checkOutput("b2b_b_result", 32'(lastResult), 32'h8001);
        checkOutput("b2b_b_accept", 32'(lastAccept), 32'd2);
        checkOutput("b2b_b_latency", 32'(lastLatency), 32'(LEN0 + 2));
        @(posedge clk);
        #1;

        $display("[TB] backpressure in DONE");
        out_ready = 1'b0;
        word = 16'($urandom);
        applyStimulus(word, "bp");
        held = refResult(word, START0, LEN0);
        checkOutput("bp_result", 32'(lastResult), 32'(held));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = 16'($urandom);
            @(posedge clk);
            #1;
            checkOutput("bp_flags", {29'd0, out_valid, in_ready, mux_en}, 32'h4);
            checkOutput("bp_hold", {out_data, mux_data}, {held, word});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release", {29'd0, out_valid, in_ready, mux_en}, 32'h2);

        $display("[TB] reset at scan step 7");
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 16'hBEEF;
        steps = 0;
        while (!(mux_en && mux_sel == 4'd7) && steps < 40) begin
            @(posedge clk);
            #1;
            steps++;
            if (mux_en) in_valid = 1'b0;
        end
        checkOutput("rst_step7", {27'd0, mux_en, mux_sel}, {27'd0, 1'b1, 4'd7});
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_async_flags", {29'd0, in_ready, out_valid, mux_en}, 32'h4);
        checkOutput("rst_async_data", {mux_data, out_data}, 32'h0);
        checkOutput("rst_async_sel", 32'(mux_sel), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h0001, "after_rst");
        checkOutput("after_rst_result", 32'(lastResult), 32'h0001);
        checkOutput("after_rst_latency", 32'(lastLatency), 32'(LEN0 + 1));
        @(posedge clk);
        #1;

        $display("[TB] narrow instance SEL_START=4 SCAN_LEN=3");
        for (int w = 0; w < 2; w++) begin
            int edges;
            int scan;
            word = (w == 0) ? 16'hFFFF : 16'($urandom);
            @(negedge clk);
            in_valid2 = 1'b1;
            in_data2 = word;
            edges = 0;
            scan = 0;
            while ((edges == 0 || !out_valid2) && edges < 40) begin
                @(posedge clk);
                #1;
                edges++;
                if (mux_en2) begin
                    in_valid2 = 1'b0;
                    checkOutput("narrow_sel", 32'(mux_sel2), 32'(START1 + scan));
                    scan++;
                end
            end
            in_valid2 = 1'b0;
            checkOutput("narrow_result", 32'(out_data2), 32'(refResult(word, START1, LEN1)));
            checkOutput("narrow_scan_cycles", 32'(scan), 32'(LEN1));
            checkOutput("narrow_latency", 32'(edges), 32'(LEN1 + 1));
            checkOutput("narrow_last_sel", 32'(mux_sel2), 32'(START1 + LEN1 - 1));
            @(posedge clk);
            #1;
        end

`ifdef MUX_SCAN_PARITY_EN
        $display("[TB] parity output");
        applyStimulus(16'h0007, "par7");
        checkOutput("parity_0007", 32'(out_parity), 32'($countones(refResult(16'h0007, START0, LEN0)) % 2));
        @(posedge clk);
        #1;
        applyStimulus(16'h0003, "par3");
        checkOutput("parity_0003", 32'(out_parity), 32'($countones(refResult(16'h0003, START0, LEN0)) % 2));
        @(posedge clk);
        #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
